// File: rtl/dragon_pkg.sv
// Shared definitions for the dragon body controller and the dragon body.
// The lengthUpdate codes here are the ones the body decodes.
package dragon_pkg;

    // Codes carried on lengthUpdate from the controller to the body
    typedef enum logic [1:0] {
        LU_MOVE = 2'b00,
        LU_HEAL = 2'b01,
        LU_HIT  = 2'b10,
        LU_IDLE = 2'b11
    } length_update_t;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } ctrl_state_t;

    localparam int COUNTER_W = 6;
    localparam int LEN_W     = 3;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vsync producing a registered one-cycle frame pulse.
// Shared by any block that needs to run at frame rate.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    // Remember the previous vsync and flag the low-to-high transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync & ~vsync_q;
        end
    end

endmodule

// File: rtl/dragon_length_ctrl.sv
// Dragon length controller: movement counter, heal/hit request latches,
// length sequencing FSM and post-hit invulnerability cooldown.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | grow INIT_LEN segments, one HEAL every other cycle
//   ST_RUN  | service one pending hit or heal per movement step
//   ST_OVER | length hit zero; counter frozen, requests ignored
module dragon_length_ctrl
    import dragon_pkg::*;
#(
    parameter int MOVE_PERIOD  = 10,
    parameter int MAX_LEN      = 7,
    parameter int INIT_LEN     = 3,
    parameter int HIT_COOLDOWN = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 heal_req,
    input  logic                 hit_req,
    output logic [COUNTER_W-1:0] movementCounter,
    output logic [1:0]           lengthUpdate,
    output logic                 move_tick,
    output logic [LEN_W-1:0]     length,
    output logic                 invuln,
    output logic                 game_over
);

    localparam int CD_W = (HIT_COOLDOWN < 2) ? 1 : $clog2(HIT_COOLDOWN + 1);
    localparam logic [COUNTER_W-1:0] MOVE_LAST = COUNTER_W'(MOVE_PERIOD);
    localparam logic [LEN_W-1:0]     LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]     LEN_INIT  = LEN_W'(INIT_LEN);
    localparam logic [CD_W-1:0]      CD_LOAD   = CD_W'(HIT_COOLDOWN);

    ctrl_state_t    state;
    length_update_t lu_q;
    logic           frame_tick;
    logic           init_phase;
    logic           heal_pend;
    logic           hit_pend;
    logic           hit_service;
    logic           heal_service;
    logic [CD_W-1:0] cooldown;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    // Steps fire on the frame that wraps the counter; nothing moves once the game is over
    assign move_tick    = frame_tick && (movementCounter == MOVE_LAST) && (state != ST_OVER);
    assign hit_service  = (state == ST_RUN) && move_tick && hit_pend;
    assign heal_service = (state == ST_RUN) && move_tick && !hit_pend && heal_pend;
    assign lengthUpdate = lu_q;

    // Frame counter shared with the body: 0..MOVE_PERIOD, frozen in OVER
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            movementCounter <= '0;
        end else if (frame_tick && (state != ST_OVER)) begin
            if (movementCounter == MOVE_LAST)
                movementCounter <= '0;
            else
                movementCounter <= movementCounter + 1'b1;
        end
    end

    // Request latches; a new request wins over a same-cycle service clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            heal_pend <= 1'b0;
            hit_pend  <= 1'b0;
        end else if (state != ST_OVER) begin
            heal_pend <= heal_req | (heal_pend & ~heal_service);
            hit_pend  <= (hit_req & ~invuln) | (hit_pend & ~hit_service);
        end
    end

    // Length sequencing FSM with registered lengthUpdate, length and game_over
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            lu_q       <= LU_MOVE;
            length     <= '0;
            init_phase <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            lu_q <= LU_MOVE;
            case (state)
                ST_INIT: begin
                    // length doubles as the count of INIT HEAL pulses issued
                    if (length == LEN_INIT) begin
                        state <= ST_RUN;
                    end else if (init_phase) begin
                        init_phase <= 1'b0;
                    end else begin
                        lu_q       <= LU_HEAL;
                        length     <= length + 1'b1;
                        init_phase <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hit_service) begin
                        lu_q <= LU_HIT;
                        if (length <= LEN_W'(1)) begin
                            length    <= '0;
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                        end else begin
                            length <= length - 1'b1;
                        end
                    end else if (heal_service && (length < LEN_MAX)) begin
                        lu_q   <= LU_HEAL;
                        length <= length + 1'b1;
                    end
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Invulnerability window: loaded on a serviced hit, counts frames down to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cooldown <= '0;
            invuln   <= 1'b0;
        end else if (hit_service) begin
            cooldown <= CD_LOAD;
            invuln   <= (HIT_COOLDOWN != 0);
        end else if (frame_tick && (cooldown != '0)) begin
            cooldown <= cooldown - 1'b1;
            if (cooldown == CD_W'(1))
                invuln <= 1'b0;
        end
    end

endmodule
